match_burst_monitor: RTL
========================

MATCH_BURST_MONITOR -- requirements
Module: match_burst_monitor

Interface
REQ-001 Parameter WINDOW, default 64, window length in clk cycles (>=2).
REQ-002 Parameter THRESH, default 4, matches per window that qualify as a burst (>=1).
REQ-003 Parameter CNT_W, default 8, width of the per-window hit counter and of rpt_count.
REQ-004 Parameter IDX_W, default 8, width of the window index.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high; forces the reset state of REQ-020.
REQ-007 z  input  1  match pulse from the upstream Moore sequence detector; each high cycle is one match.
REQ-008 clr  input  1  synchronous clear of total and ovf.
REQ-009 rpt_ready  input  1  consumer accepts the report.
REQ-010 rpt_valid  output  1  report record held valid.
REQ-011 rpt_count  output  CNT_W  hit count of the reported window.
REQ-012 rpt_win  output  IDX_W  index of the reported window.
REQ-013 alarm  output  1  current window has reached THRESH.
REQ-014 total  output  16  saturating count of all matches since reset or clr.
REQ-015 ovf  output  1  sticky: a report was dropped.

Function
REQ-016 Window timer counts 0..WINDOW-1 and wraps; the cycle with timer == WINDOW-1 is the window-end cycle; win_idx increments modulo 2^IDX_W on each window end.
REQ-017 hits increments on each z=1 cycle, saturating at 2^CNT_W-1; final = hits + z (saturated) on the window-end cycle; hits = 0 in the cycle after window end.
REQ-018 alarm registered: 1 in the cycle after hits reaches THRESH; cleared together with hits at window rollover.
REQ-019 total increments on each z=1 cycle, saturating at 65535; clr=1 sets total=0 and ovf=0, taking priority over a same-cycle z.
REQ-020 Report FSM states: EMPTY (rpt_valid=0) and FULL (rpt_valid=1).
REQ-021 EMPTY: at window end with final >= THRESH, load rpt_count=final and rpt_win=win_idx; go to FULL next cycle.
REQ-022 FULL: rpt_valid, rpt_count and rpt_win stay stable until a cycle with rpt_ready=1; that cycle is the transfer.
REQ-023 FULL with transfer and no new report: go to EMPTY.
REQ-024 FULL with transfer and a same-cycle qualifying window end: load the new record and stay FULL (no bubble, no drop).
REQ-025 FULL without transfer and a qualifying window end: drop the new record, keep the old one, set ovf=1.
REQ-026 rpt_ready is ignored in EMPTY.
REQ-027 Latency: rpt_valid rises exactly 1 cycle after the qualifying window-end cycle.

Reset
REQ-028 While reset=1 (asynchronously): timer=0, win_idx=0, hits=0, alarm=0, total=0, ovf=0, rpt_valid=0, rpt_count=0, rpt_win=0, FSM=EMPTY.
REQ-029 Reset mid-window or mid-report discards all partial counts and any pending record; the first window after release starts at timer=0 with index 0.

Verification
REQ-030 WINDOW=8, THRESH=2: z pulses at timer 1 and 4 of window 0, rpt_ready=1 -> rpt_valid=1 for one cycle at timer 0 of window 1, rpt_count=2, rpt_win=0; alarm high from timer 5 to timer 7.
REQ-031 Single z in window 0 with THRESH=2 -> no report, alarm stays 0, total=1.
REQ-032 Qualifying windows 0 and 1 with rpt_ready=0 -> record (count, win 0) held stable, ovf=1 after window 1 end; rpt_ready=1 -> window 0 record transferred, FSM goes to EMPTY.
REQ-033 FULL and rpt_ready=1 on the window-1 end cycle -> window 1 record loaded back-to-back, rpt_valid stays 1, ovf=0.
REQ-034 z held high for 300 cycles with CNT_W=8, WINDOW=512 -> hits saturates at 255, reported rpt_count=255; total=300; clr asserted -> total=0, ovf=0.
REQ-035 reset pulse at timer 3 with hits=2 -> all outputs 0 immediately; next report carries rpt_win=0.

Source files
------------

// File: rtl/match_burst_monitor_if.sv
// Report channel of the match burst monitor: one held record with a
// valid/ready handshake. The monitor drives the record (master) and the
// consumer drives rpt_ready (slave).
interface match_burst_monitor_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned IDX_W = 8
);
    logic             rpt_valid;
    logic             rpt_ready;
    logic [CNT_W-1:0] rpt_count;
    logic [IDX_W-1:0] rpt_win;

    modport master (
        output rpt_valid,
        output rpt_count,
        output rpt_win,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_count,
        input  rpt_win,
        output rpt_ready
    );
endinterface

// File: rtl/match_burst_monitor.sv
// Match burst monitor.
// Counts match pulses (z) from an upstream sequence detector inside fixed
// windows of WINDOW cycles. A window whose final hit count reaches THRESH
// produces a report record {count, window index} that is held on a
// valid/ready channel until the consumer takes it. While a record is still
// pending, further qualifying windows are dropped and flagged in the
// sticky ovf bit. A saturating total of all matches and a live alarm for
// the current window are also provided.
module match_burst_monitor #(
    parameter int unsigned WINDOW = 64,
    parameter int unsigned THRESH = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned IDX_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   z,
    input  logic                   clr,
    match_burst_monitor_if.master  rpt,
    output logic                   alarm,
    output logic [15:0]            total,
    output logic                   ovf
);

    localparam int unsigned       TMR_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]       TOT_MAX  = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Saturating increment of a window hit count.
    function automatic logic [CNT_W-1:0] sat_inc_cnt(
        input logic [CNT_W-1:0] v,
        input logic             inc
    );
        logic [CNT_W-1:0] r;
        if (inc && (v != CNT_MAX)) begin
            r = v + CNT_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Saturating increment of the 16-bit running total.
    function automatic logic [15:0] sat_inc_tot(
        input logic [15:0] v,
        input logic        inc
    );
        logic [15:0] r;
        if (inc && (v != TOT_MAX)) begin
            r = v + 16'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [TMR_W-1:0] timer_r;
    logic [IDX_W-1:0] win_idx_r;
    logic [CNT_W-1:0] hits_r;
    logic             alarm_r;
    logic [15:0]      total_r;
    logic             ovf_r;
    state_t           state_r;
    logic             rpt_valid_r;
    logic [CNT_W-1:0] rpt_count_r;
    logic [IDX_W-1:0] rpt_win_r;

    logic             win_end_s;
    logic [CNT_W-1:0] final_s;
    logic             qualify_s;
    logic             drop_s;

    // Window-end detection, the window's final count (including a match
    // landing on the last cycle) and the qualify/drop decisions.
    always_comb begin
        win_end_s = 1'b0;
        final_s   = sat_inc_cnt(hits_r, z);
        qualify_s = 1'b0;
        drop_s    = 1'b0;
        if (timer_r == TMR_LAST) begin
            win_end_s = 1'b1;
        end else begin
            win_end_s = 1'b0;
        end
        if (win_end_s && (32'(final_s) >= THRESH)) begin
            qualify_s = 1'b1;
        end else begin
            qualify_s = 1'b0;
        end
        if ((state_r == ST_FULL) && !rpt.rpt_ready && qualify_s) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // Window timer and window index; the index advances on every window end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_r   <= '0;
            win_idx_r <= '0;
        end else if (win_end_s) begin
            timer_r   <= '0;
            win_idx_r <= win_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            timer_r   <= timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
        end
    end

    // Per-window hit counter and alarm; both restart at window rollover.
    // alarm tracks the updated count so it is high whenever hits >= THRESH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits_r  <= '0;
            alarm_r <= 1'b0;
        end else if (win_end_s) begin
            hits_r  <= '0;
            alarm_r <= 1'b0;
        end else begin
            hits_r  <= final_s;
            alarm_r <= (32'(final_s) >= THRESH);
        end
    end

    // Running total and sticky overflow; clr wins over a same-cycle match
    // or drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_r <= 16'd0;
            ovf_r   <= 1'b0;
        end else if (clr) begin
            total_r <= 16'd0;
            ovf_r   <= 1'b0;
        end else begin
            total_r <= sat_inc_tot(total_r, z);
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Report holding FSM: EMPTY loads on a qualifying window end; FULL holds
    // the record until rpt_ready, reloading in the transfer cycle when a new
    // qualifying window ends at the same time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            rpt_valid_r <= 1'b0;
            rpt_count_r <= '0;
            rpt_win_r   <= '0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (qualify_s) begin
                        state_r     <= ST_FULL;
                        rpt_valid_r <= 1'b1;
                        rpt_count_r <= final_s;
                        rpt_win_r   <= win_idx_r;
                    end
                end
                ST_FULL: begin
                    if (rpt.rpt_ready) begin
                        if (qualify_s) begin
                            state_r     <= ST_FULL;
                            rpt_valid_r <= 1'b1;
                            rpt_count_r <= final_s;
                            rpt_win_r   <= win_idx_r;
                        end else begin
                            state_r     <= ST_EMPTY;
                            rpt_valid_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    rpt_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign rpt.rpt_valid = rpt_valid_r;
    assign rpt.rpt_count = rpt_count_r;
    assign rpt.rpt_win   = rpt_win_r;
    assign alarm         = alarm_r;
    assign total         = total_r;
    assign ovf           = ovf_r;

endmodule
